// File: rtl/fp32_seq_divider_if.sv
// Handshake bundle for fp32_seq_divider.
//   Input side : in_valid, in_ready, Dividend, Divisor
//   Output side: out_valid, out_ready, Quotient
//                (plus Flags = {invalid, div_by_zero, overflow, underflow}
//                 when FP_DIV_EXC_FLAGS_EN is defined)
// The slave modport is the divider; the master modport is whoever feeds
// operands and consumes results.
interface fp32_seq_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Quotient;
`ifdef FP_DIV_EXC_FLAGS_EN
  logic [3:0]  Flags;
`endif

  modport slave (
    input  in_valid, Dividend, Divisor, out_ready,
    output in_ready, out_valid, Quotient
`ifdef FP_DIV_EXC_FLAGS_EN
    , output Flags
`endif
  );

  modport master (
    output in_valid, Dividend, Divisor, out_ready,
    input  in_ready, out_valid, Quotient
`ifdef FP_DIV_EXC_FLAGS_EN
    , input Flags
`endif
  );
endinterface

// File: rtl/fp32_seq_divider.sv
// Iterative IEEE-754 single-precision divider, Quotient = Dividend / Divisor.
// Restoring radix-2 mantissa division producing BITS_PER_CYCLE (1 or 2)
// quotient bits per clock, 26 bits in total (24 + guard + round), with the
// final remainder as sticky. Round-to-nearest-even; subnormals flushed to zero.
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   bus         fp32_seq_divider_if.slave: in_valid/in_ready + Dividend/Divisor,
//               out_valid/out_ready + Quotient (Flags when FP_DIV_EXC_FLAGS_EN)
// Optional feature: define FP_DIV_EXC_FLAGS_EN to add the Flags output
// {invalid, div_by_zero, overflow, underflow}, valid with out_valid.
module fp32_seq_divider #(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  fp32_seq_divider_if.slave   bus
);

  localparam int         ITER_CYCLES = 26 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT    = 5'(ITER_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        opa_q, opa_d, opb_q, opb_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [25:0]        rem_q, rem_d;
  logic [25:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               special_q, special_d;
  logic [31:0]        res_q, res_d;
`ifdef FP_DIV_EXC_FLAGS_EN
  logic [3:0]         flags_q, flags_d;
`endif

  // Operand classification (exponent field 0 counts as zero).
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (opa_q[30:23] == 8'h00);
  assign b_zero = (opb_q[30:23] == 8'h00);
  assign a_inf  = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] == 23'd0);
  assign b_inf  = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] == 23'd0);
  assign a_nan  = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != 23'd0);
  assign b_nan  = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != 23'd0);

  // One ITER cycle worth of restoring steps; quotient bits enter at the LSB
  // so after 26 steps quo[25] carries weight 2^0.
  logic [25:0] rem_step, quo_step;
  always_comb begin
    rem_step = rem_q;
    quo_step = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_step >= {2'b00, mb_q}) begin
        rem_step = (rem_step - {2'b00, mb_q}) << 1;
        quo_step = {quo_step[24:0], 1'b1};
      end else begin
        rem_step = rem_step << 1;
        quo_step = {quo_step[24:0], 1'b0};
      end
    end
  end

  // Normalise and round. A quotient below 1.0 drops one bit, so guard moves
  // down one place and the remainder alone covers everything past it.
  logic signed [9:0] norm_exp, fin_exp;
  logic [23:0]       mant_pre;
  logic [24:0]       mant_rnd;
  logic [22:0]       fin_mant;
  logic              guard, rest, round_up;
  always_comb begin
    norm_exp = exp_q;
    mant_pre = quo_q[25:2];
    guard    = quo_q[1];
    rest     = quo_q[0] | (rem_q != 26'd0);
    if (!quo_q[25]) begin
      norm_exp = exp_q - 10'sd1;
      mant_pre = quo_q[24:1];
      guard    = quo_q[0];
      rest     = (rem_q != 26'd0);
    end
    round_up = guard & (rest | mant_pre[0]);
    mant_rnd = {1'b0, mant_pre} + 25'(round_up);
    fin_exp  = norm_exp;
    fin_mant = mant_rnd[22:0];
    if (mant_rnd[24]) begin
      fin_exp  = norm_exp + 10'sd1;
      fin_mant = mant_rnd[23:1];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mb_d      = mb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    res_d     = res_q;
`ifdef FP_DIV_EXC_FLAGS_EN
    flags_d   = flags_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.Dividend;
          opb_d   = bus.Divisor;
          state_d = PREP;
        end
      end
      PREP: begin
        sign_d    = opa_q[31] ^ opb_q[31];
        exp_d     = $signed({2'b00, opa_q[30:23]}) - $signed({2'b00, opb_q[30:23]}) + 10'sd127;
        mb_d      = {1'b1, opb_q[22:0]};
        rem_d     = {3'b001, opa_q[22:0]};
        quo_d     = '0;
        cnt_d     = '0;
        special_d = 1'b1;
`ifdef FP_DIV_EXC_FLAGS_EN
        flags_d   = 4'b0000;
`endif
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d = 32'h7FC0_0000;
`ifdef FP_DIV_EXC_FLAGS_EN
          flags_d = 4'b1000;
`endif
        end else if (a_inf) begin
          res_d = {opa_q[31] ^ opb_q[31], 8'hFF, 23'd0};
        end else if (b_zero) begin
          res_d = {opa_q[31] ^ opb_q[31], 8'hFF, 23'd0};
`ifdef FP_DIV_EXC_FLAGS_EN
          flags_d = 4'b0100;
`endif
        end else if (b_inf || a_zero) begin
          res_d = {opa_q[31] ^ opb_q[31], 31'd0};
        end else begin
          special_d = 1'b0;
        end
        // Special results skip ITER and pass ROUND untouched (2-cycle latency).
        state_d = (special_d) ? ROUND : ITER;
      end
      ITER: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) state_d = ROUND;
      end
      ROUND: begin
        if (!special_q) begin
          if (fin_exp >= 10'sd255) begin
            res_d = {sign_q, 8'hFF, 23'd0};
`ifdef FP_DIV_EXC_FLAGS_EN
            flags_d = 4'b0010;
`endif
          end else if (fin_exp <= 10'sd0) begin
            // The quotient of two nonzero finites is nonzero, so any flush
            // here is an underflow.
            res_d = {sign_q, 31'd0};
`ifdef FP_DIV_EXC_FLAGS_EN
            flags_d = 4'b0001;
`endif
          end else begin
            res_d = {sign_q, fin_exp[7:0], fin_mant};
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are plain flops, not memory, so resetting them
  // to zero is cheap and keeps Quotient defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mb_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      special_q <= 1'b0;
      res_q     <= '0;
`ifdef FP_DIV_EXC_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mb_q      <= mb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      res_q     <= res_d;
`ifdef FP_DIV_EXC_FLAGS_EN
      flags_q   <= flags_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Quotient  = res_q;
`ifdef FP_DIV_EXC_FLAGS_EN
  assign bus.Flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Self-checking bench for fp32_seq_divider: directed cases, back-pressure,
// mid-operation reset, then random operands against an integer reference
// model of correctly rounded single-precision division.
module tb_fp32_seq_divider;

  localparam int BPC        = 1;
  localparam int NORM_LAT   = 2 + 26 / BPC;
  localparam int SPEC_LAT   = 2;
  localparam int WAIT_LIMIT = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fp32_seq_divider_if dif ();

  fp32_seq_divider #(.BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Correctly rounded quotient from the operand values: exact integer
  // division of the significands, remainder compared against half the divisor.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint unsigned ma, mb, num, q, r;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
    if (a_inf || b_zero) return {s, 8'hFF, 23'd0};
    if (b_inf || a_zero) return {s, 31'd0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    e  = ea - eb + 127;
    if (ma >= mb) num = ma << 23;
    else begin
      num = ma << 24;
      e   = e - 1;
    end
    q = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
      3:       begin v[30:23] = 8'($urandom_range(1, 254)); v[22:0] = '0; end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Presents one operand pair; returns #1 after the accept edge with the
  // operand bus scrambled so late changes would show up as wrong results.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.Dividend = a;
    dif.Divisor  = b;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    dif.Dividend = $urandom;
    dif.Divisor  = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (dif.out_valid !== 1'b1 && lat < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("result_within_limit", 32'(lat < WAIT_LIMIT), 32'd1);
  endtask

  task automatic consume();
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input int exp_lat,
                        input bit chk_flags, input logic [3:0] exp_flags);
    int lat;
    start_op(a, b);
    wait_result(lat);
    check(tag, dif.Quotient, exp_q);
    if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
`ifdef FP_DIV_EXC_FLAGS_EN
    if (chk_flags) check({tag, "_flags"}, 32'(dif.Flags), 32'(exp_flags));
`endif
    consume();
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.Dividend  = '0;
    dif.Divisor   = '0;

    // Reset state
    #12;
    check("reset_in_ready",  32'(dif.in_ready),  32'd1);
    check("reset_out_valid", 32'(dif.out_valid), 32'd0);
    check("reset_quotient",  dif.Quotient,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic and special cases
    run_op("exact_1729",  32'h4B5482B7, 32'h45FBB800, 32'h44D82000, NORM_LAT, 1, 4'b0000);
    run_op("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NORM_LAT, 1, 4'b0000);
    run_op("six_by_m2",   32'h40C00000, 32'hC0000000, 32'hC0400000, 0,        1, 4'b0000);
    run_op("m1_by_zero",  32'hBF800000, 32'h00000000, 32'hFF800000, SPEC_LAT, 1, 4'b0100);
    run_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, SPEC_LAT, 1, 4'b1000);
    run_op("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, NORM_LAT, 1, 4'b0010);
    run_op("nan_in",      32'h7FC12345, 32'h3F800000, 32'h7FC00000, SPEC_LAT, 1, 4'b1000);
    run_op("inf_by_two",  32'hFF800000, 32'h40000000, 32'hFF800000, SPEC_LAT, 1, 4'b0000);
    run_op("two_by_inf",  32'h40000000, 32'hFF800000, 32'h80000000, SPEC_LAT, 1, 4'b0000);
    run_op("inf_by_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, SPEC_LAT, 1, 4'b1000);
    run_op("zero_by_m3",  32'h00000000, 32'hC0400000, 32'h80000000, SPEC_LAT, 1, 4'b0000);
    run_op("min_normal",  32'h00800000, 32'h3F800000, 32'h00800000, 0,        1, 4'b0000);
    run_op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 0,        1, 4'b0001);

    // Back-pressure: result held while out_ready=0, new operands refused
    start_op(32'h4B5482B7, 32'h45FBB800);
    wait_result(lat);
    dif.in_valid = 1'b1;
    dif.Dividend = 32'h40000000;
    dif.Divisor  = 32'h3F800000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_quotient",  dif.Quotient,       32'h44D82000);
      check("hold_out_valid", 32'(dif.out_valid), 32'd1);
      check("hold_in_ready",  32'(dif.in_ready),  32'd0);
    end
    dif.in_valid = 1'b0;
    consume();
    check("after_pop_out_valid", 32'(dif.out_valid), 32'd0);
    check("after_pop_in_ready",  32'(dif.in_ready),  32'd1);

    // Reset in the middle of ITER aborts the operation
    start_op(32'h3F800000, 32'h40400000);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(dif.out_valid), 32'd0);
    check("abort_in_ready",  32'(dif.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NORM_LAT, 1, 4'b0000);

    // Random operands against the reference model
    for (int n = 0; n < 300; n++) begin
      a = rand_fp();
      b = rand_fp();
      run_op("random", a, b, ref_div(a, b), 0, 0, 4'b0000);
      if (dif.Quotient !== ref_div(a, b) && bad < 4)
        $display("  operands %h / %h", a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
